// File: rtl/alu_writeback.sv
// Writeback stage: commits memory load data (fixed priority) and ALU results to the
// register-file write port, queueing colliding ALU results in an in-order circular buffer.
module alu_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [DATA_W-1:0]            alu_data,
  input  logic [ADDR_W-1:0]            alu_rd,
  input  logic                         mem_valid,
  input  logic [DATA_W-1:0]            mem_data,
  input  logic [ADDR_W-1:0]            mem_rd,
  output logic                         rf_we,
  output logic [ADDR_W-1:0]            rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  output logic [$clog2(DEPTH):0]       pending
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    PARTIAL = 2'd1,
    FULL    = 2'd2
  } q_state_t;

  q_state_t          q_state;
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_rd   [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              accept_nz;
  logic              push;
  logic              pop;
  logic              we_next;
  logic [ADDR_W-1:0] waddr_next;
  logic [DATA_W-1:0] wdata_next;

  // Occupancy state derived from the pending count
  always_comb begin
    if (pending == {CW{1'b0}}) begin
      q_state = EMPTY;
    end else if (pending == FULL_CNT) begin
      q_state = FULL;
    end else begin
      q_state = PARTIAL;
    end
  end

  assign alu_ready = (q_state != FULL) && !rst;
  assign accept_nz = alu_valid && alu_ready && (alu_rd != {ADDR_W{1'b0}});

  // Write-port select: mem, then queue head, then bypass; unwritten ALU results are pushed
  always_comb begin
    we_next    = 1'b0;
    waddr_next = rf_waddr;
    wdata_next = rf_wdata;
    push       = 1'b0;
    pop        = 1'b0;
    case (q_state)
      EMPTY, PARTIAL, FULL: begin
        if (mem_valid) begin
          push = accept_nz;
          if (mem_rd != {ADDR_W{1'b0}}) begin
            we_next    = 1'b1;
            waddr_next = mem_rd;
            wdata_next = mem_data;
          end else begin
            we_next = 1'b0;
          end
        end else if (q_state != EMPTY) begin
          pop        = 1'b1;
          push       = accept_nz;
          we_next    = 1'b1;
          waddr_next = q_rd[rd_ptr];
          wdata_next = q_data[rd_ptr];
        end else if (accept_nz) begin
          we_next    = 1'b1;
          waddr_next = alu_rd;
          wdata_next = alu_data;
        end else begin
          we_next = 1'b0;
        end
      end
      default: begin
        we_next = 1'b0;
      end
    endcase
  end

  // Registered write port
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we    <= 1'b0;
      rf_waddr <= {ADDR_W{1'b0}};
      rf_wdata <= {DATA_W{1'b0}};
    end else begin
      rf_we    <= we_next;
      rf_waddr <= waddr_next;
      rf_wdata <= wdata_next;
    end
  end

  // Queue pointers and occupancy; reset discards any queued entries
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= {PW{1'b0}};
      rd_ptr  <= {PW{1'b0}};
      pending <= {CW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      pending <= pending + CW'(push) - CW'(pop);
    end
  end

  // Queue storage, written only at the tail
  always_ff @(posedge clk) begin
    if (push) begin
      q_data[wr_ptr] <= alu_data;
      q_rd[wr_ptr]   <= alu_rd;
    end
  end

endmodule
